ps2_frame_receiver: RTL and testbench

PS/2 device-to-host frame receiver. It sits directly upstream of the keyboard decoder and takes the raw `ps2_clock`/`ps2_data` pins. It synchronises and deglitches them, deserialises 11-bit frames and checks parity and stop bits. Each valid scan-code byte is handed downstream through a single-entry ready/read_fin buffer.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_line_filter.sv | 56 +++++
 rtl/ps2_frame_receiver.sv | 149 ++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and FSM state type for the PS/2 frame receiver
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchroniser plus run-length deglitch with a falling-edge strobe
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int RUN_W = $clog2(FILTER_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             fall_q, fall_d;
  logic [RUN_W-1:0] run_q, run_d;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      run_d = '0;
    end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
      level_d = sync2_q;
      run_d   = '0;
      fall_d  = ~sync2_q;
    end else begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      run_q   <= run_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 device-to-host frame receiver with single-entry output buffer
// Optional odd-parity enforcement: PS2_PARITY_CHECK_EN.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ps2_clock,
  input  logic                     ps2_data,
  input  logic                     read_fin,
  output logic                     ready,
  output logic [PS2_DATA_BITS-1:0] data,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(PS2_DATA_BITS);

  logic clk_level, clk_fall, bit_ev;
  logic dsync1_q, dsync2_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock(clock),
    .reset(reset),
    .din  (ps2_clock),
    .level(clk_level),
    .fall (clk_fall)
  );

  assign bit_ev = clk_fall && !clk_level;

  ps2_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                     ready_q, ready_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     commit, frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic                     parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ready_d     = ready_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
    frame_ok    = dsync2_q && (^{shift_q, parity_q});
`else
    frame_ok    = dsync2_q;
`endif
    tmo_d = (state_q == ST_IDLE || bit_ev) ? '0 : tmo_q + TMO_W'(1);

    if (bit_ev) begin
      case (state_q)
        ST_IDLE: begin
          if (!dsync2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {dsync2_q, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dsync2_q;
`endif
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          commit      = frame_ok;
          frame_err_d = !frame_ok;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      shift_d     = '0;
      tmo_d       = '0;
    end

    // A read in the commit cycle frees the slot for the incoming byte.
    if (commit) begin
      if (!ready_q || read_fin) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (read_fin && ready_q) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dsync1_q    <= 1'b1;
      dsync2_q    <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      dsync1_q    <= ps2_data;
      dsync2_q    <= dsync1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign data      = data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb/tb_ps2_frame_receiver.sv - directed plus randomized frames against a frame-level reference model
module tb_ps2_frame_receiver;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_fin = 1'b0;
  logic       ready;
  logic [7:0] data;
  logic       frame_err;
  logic       overrun;

  always #5 clock = ~clock;

  ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .read_fin (read_fin),
    .ready    (ready),
    .data     (data),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int   n_assert = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  int   ovr_cnt = 0;
  int   exp_err = 0;
  int   exp_ovr = 0;
  bit   exp_ready = 1'b0;
  logic [7:0] exp_data = 8'h00;

  always @(negedge clock) begin
    if (frame_err === 1'b1) err_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input bit b);
    ps2_data = b;
    cycles(HALF);
    ps2_clock = 1'b0;
    cycles(HALF);
    ps2_clock = 1'b1;
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input bit badp, input bit bads, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return (~^b) ^ badp;
    return ~bads;
  endfunction

  task automatic read_pulse();
    read_fin = 1'b1;
    cycles(1);
    read_fin = 1'b0;
    exp_ready = 1'b0;
    check("read_clears_ready", ready, exp_ready);
    check("read_data_hold", data, exp_data);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badp, input bit bads, input bit rf,
                            input int glitch_at, input int reset_at);
    bit par, valid, par_ok;
    for (int i = 0; i < 10; i++) begin
      if (i == glitch_at) begin
        ps2_clock = 1'b0;
        cycles(3);
        ps2_clock = 1'b1;
        cycles(HALF);
      end
      if (i == reset_at) begin
        reset = 1'b1;
        #2;
        check("rst_ready", ready, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        cycles(2);
        reset = 1'b0;
        exp_ready = 1'b0;
        exp_data = 8'h00;
        cycles(HALF);
        return;
      end
      send_bit(frame_bit(b, badp, bads, i));
    end
    par = frame_bit(b, badp, bads, 9);
`ifdef PS2_PARITY_CHECK_EN
    par_ok = ($countones({b, par}) % 2) == 1;
`else
    par_ok = 1'b1;
`endif
    valid = frame_bit(b, badp, bads, 10) && par_ok;
    ps2_data = frame_bit(b, badp, bads, 10);
    cycles(HALF);
    ps2_clock = 1'b0;
    cycles(2 + FL);
    check($sformatf("ready_before_commit_%02h", b), ready, exp_ready);
    if (rf) read_fin = 1'b1;
    cycles(1);
    read_fin = 1'b0;
    if (valid) begin
      if (!exp_ready || rf) begin
        exp_data = b;
        exp_ready = 1'b1;
      end else begin
        exp_ovr++;
      end
    end else begin
      exp_err++;
      if (rf) exp_ready = 1'b0;
    end
    check($sformatf("ready_after_commit_%02h", b), ready, exp_ready);
    check($sformatf("data_after_commit_%02h", b), data, exp_data);
    cycles(HALF - 3 - FL);
    ps2_clock = 1'b1;
    cycles(HALF);
    check($sformatf("frame_err_pulses_%02h", b), err_cnt, exp_err);
    check($sformatf("overrun_pulses_%02h", b), ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [7:0] rb;
    int         kind;
    bit         rrf;

    #1;
    check("reset_ready", ready, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    cycles(3);
    reset = 1'b0;
    cycles(5);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, -1, -1);
    read_pulse();
    read_pulse();

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, -1, -1);
    read_pulse();

    send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1, -1);

    for (int i = 0; i < 5; i++) send_bit(frame_bit(8'hF0, 1'b0, 1'b0, i));
    ps2_data = 1'b1;
    cycles(TMO - 200);
    check("timeout_not_early", err_cnt, exp_err);
    cycles(400);
    exp_err++;
    check("timeout_frame_err", err_cnt, exp_err);
    check("timeout_ready", ready, exp_ready);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, -1, -1);
    read_pulse();

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, -1, -1);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0, -1, -1);
    check("overrun_keeps_data", data, 8'h1C);
    read_pulse();

    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 4, -1);
    check("glitch_data", data, 8'h5A);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 6);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, -1, -1);
    check("after_reset_data", data, 8'h29);

    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1, -1);

    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 3));
      rrf = 1'($urandom_range(0, 1));
      send_frame(rb, kind == 0, kind == 1, rrf, -1, -1);
      if ($urandom_range(0, 2) == 0) read_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
